// File: rtl/jt6295_pkg.sv
// Shared constants and types for the jt6295 ADPCM encoder and decoder paths.
// Holds the OKI step table, the index increments and the encoder FSM state encoding.
package jt6295_pkg;

  localparam logic [5:0] IDX_MAX = 6'd48;

  // Index increment for codes with the m2 bit set, selected by {m1,m0}
  localparam logic [5:0] IDX_INC [4] = '{6'd2, 6'd4, 6'd6, 6'd8};

  localparam logic [10:0] STEP_LUT [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552
  };

  typedef enum logic [2:0] {
    StIdle,
    StB2,
    StB1,
    StB0,
    StRecon,
    StChk,
    StUpd
  } enc_state_t;

endpackage

// File: rtl/jt6295_step_lut.sv
// Combinational step-size ROM indexed by the ADPCM step index.
// Out-of-range indices clamp to the last entry.
module jt6295_step_lut
  import jt6295_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [10:0] step
);

  always_comb begin
    step = STEP_LUT[48];
    if (idx <= IDX_MAX) step = STEP_LUT[idx];
  end

endmodule

// File: rtl/jt6295_adpcm_enc.sv
// Single-channel OKI ADPCM encoder: successive-approximation quantiser that tracks the
// decoder's predictor and step index, backing off any code that would wrap the predictor.
module jt6295_adpcm_enc
  import jt6295_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        clr,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  input  logic [11:0] pcm,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [3:0]  code,
  output logic [11:0] pred,
  output logic [5:0]  idx
);

  enc_state_t state_q, state_d;

  logic        sign_q;
  logic [12:0] mag_q;
  logic [2:0]  m_q;
  logic [13:0] npred_q;
  logic [11:0] pred_q;
  logic [5:0]  idx_q;
  logic [3:0]  code_q;
  logic        code_valid_q;

  logic        accept;
  logic [10:0] step;
  logic [12:0] diff, mag_in;
  logic [12:0] step_w, half_w, quarter_w;
  logic        ge_step, ge_half, ge_quarter;
  logic [11:0] qn;
  logic [13:0] npred_d;
  logic        in_range;
  logic [5:0]  idx_t, idx_d;

  jt6295_step_lut u_step_lut (
    .idx  (idx_q),
    .step (step)
  );

  assign diff   = {pcm[11], pcm} - {pred_q[11], pred_q};
  assign mag_in = diff[12] ? (13'd0 - diff) : diff;

  assign step_w     = {2'b00, step};
  assign half_w     = {3'b000, step[10:1]};
  assign quarter_w  = {4'b0000, step[10:2]};
  assign ge_step    = mag_q >= step_w;
  assign ge_half    = mag_q >= half_w;
  assign ge_quarter = mag_q >= quarter_w;

  assign qn = {4'b0000, step[10:3]}
            + (m_q[2] ? {1'b0, step}        : 12'd0)
            + (m_q[1] ? {2'b00, step[10:1]} : 12'd0)
            + (m_q[0] ? {3'b000, step[10:2]} : 12'd0);

  assign npred_d = sign_q ? ({{2{pred_q[11]}}, pred_q} - {2'b00, qn})
                          : ({{2{pred_q[11]}}, pred_q} + {2'b00, qn});

  // A 14-bit value fits in 12 signed bits when its top three bits agree
  assign in_range = (npred_q[13:11] == 3'b000) || (npred_q[13:11] == 3'b111);

  assign idx_t = m_q[2] ? (idx_q + IDX_INC[m_q[1:0]]) : (idx_q - 6'd1);
  assign idx_d = (idx_t > IDX_MAX) ? (m_q[2] ? IDX_MAX : 6'd0) : idx_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (cen) begin
      if (clr) state_q <= StIdle;
      else     state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StB2;
      StB2:    state_d = StB1;
      StB1:    state_d = StB0;
      StB0:    state_d = StRecon;
      StRecon: state_d = StChk;
      StChk:   state_d = in_range ? StUpd : StRecon;
      StUpd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pcm_ready = (state_q == StIdle) && !code_valid_q;
    accept    = pcm_valid && pcm_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q       <= 1'b0;
      mag_q        <= '0;
      m_q          <= '0;
      npred_q      <= '0;
      pred_q       <= '0;
      idx_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else if (cen) begin
      if (clr) begin
        pred_q       <= '0;
        idx_q        <= '0;
        code_valid_q <= 1'b0;
      end else begin
        if (code_valid_q && code_ready) code_valid_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              sign_q <= diff[12];
              mag_q  <= mag_in;
            end
          end
          StB2: begin
            m_q[2] <= ge_step;
            if (ge_step) mag_q <= mag_q - step_w;
          end
          StB1: begin
            m_q[1] <= ge_half;
            if (ge_half) mag_q <= mag_q - half_w;
          end
          StB0:    m_q[0] <= ge_quarter;
          StRecon: npred_q <= npred_d;
          StChk: begin
            if (!in_range) begin
              if (m_q != 3'd0) m_q <= m_q - 3'd1;
              else             sign_q <= ~sign_q;
            end
          end
          StUpd: begin
            pred_q       <= npred_q[11:0];
            code_q       <= {sign_q, m_q};
            idx_q        <= idx_d;
            code_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign pred       = pred_q;
  assign idx        = idx_q;

endmodule
